// File: rtl/lock_detector.sv
// ADPLL lock detector: per-window min/max/average of the phase error drive a
// four-state lock FSM, with starvation detection on the sample stream.
module lock_detector #(
  parameter int WINDOW_LOG2    = 4,
  parameter int LOCK_THRESH    = 4,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sample_valid_i,
  input  logic signed [7:0] error_i,
  input  logic              clear_i,
  output logic [1:0]        state_o,
  output logic              locked_o,
  output logic signed [7:0] err_min_o,
  output logic signed [7:0] err_max_o,
  output logic signed [7:0] err_avg_o,
  output logic              stats_valid_o,
  output logic              timeout_o
);

  localparam int SW = 8 + WINDOW_LOG2;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'b00,
    ST_ACQUIRING = 2'b01,
    ST_LOCKED    = 2'b10,
    ST_HOLDOVER  = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [WINDOW_LOG2-1:0]  cnt_q, cnt_d;
  logic signed [7:0]       min_q, min_d, max_q, max_d;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic [15:0]             idle_q, idle_d;
  logic [3:0]              good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic signed [7:0]       err_min_q, err_min_d, err_max_q, err_max_d, err_avg_q, err_avg_d;
  logic                    stats_valid_q, stats_valid_d;
  logic                    timeout_q, timeout_d;
  logic                    locked_q, locked_d;

  // Window values including the sample presented this cycle
  logic                    first_smp, last_smp, good;
  logic signed [7:0]       min_fin, max_fin;
  logic signed [SW-1:0]    err_ext, sum_fin, avg_shift;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    min_d         = min_q;
    max_d         = max_q;
    sum_d         = sum_q;
    idle_d        = idle_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    err_min_d     = err_min_q;
    err_max_d     = err_max_q;
    err_avg_d     = err_avg_q;
    stats_valid_d = 1'b0;
    timeout_d     = timeout_q;

    first_smp = (cnt_q == '0);
    last_smp  = &cnt_q;
    err_ext   = $signed({{WINDOW_LOG2{error_i[7]}}, error_i});
    min_fin   = (first_smp || (error_i < min_q)) ? error_i : min_q;
    max_fin   = (first_smp || (error_i > max_q)) ? error_i : max_q;
    sum_fin   = first_smp ? err_ext : sum_q + err_ext;
    avg_shift = sum_fin >>> WINDOW_LOG2;
    // Signed compares against the threshold avoid taking abs() of -128
    good      = (int'(max_fin) <= LOCK_THRESH) && (int'(min_fin) >= -LOCK_THRESH);

    if (clear_i) begin
      state_d    = ST_UNLOCKED;
      cnt_d      = '0;
      min_d      = '0;
      max_d      = '0;
      sum_d      = '0;
      idle_d     = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      err_min_d  = '0;
      err_max_d  = '0;
      err_avg_d  = '0;
      timeout_d  = 1'b0;
    end else if (sample_valid_i) begin
      idle_d    = '0;
      timeout_d = 1'b0;
      if (last_smp) begin
        cnt_d         = '0;
        min_d         = '0;
        max_d         = '0;
        sum_d         = '0;
        err_min_d     = min_fin;
        err_max_d     = max_fin;
        err_avg_d     = avg_shift[7:0];
        stats_valid_d = 1'b1;
        unique case (state_q)
          ST_UNLOCKED: if (good) begin
            state_d    = ST_ACQUIRING;
            good_cnt_d = 4'd1;
          end
          ST_ACQUIRING: if (good) begin
            if (good_cnt_q + 4'd1 == 4'(LOCK_WINDOWS)) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
          end
          ST_LOCKED: if (!good) begin
            state_d   = ST_HOLDOVER;
            bad_cnt_d = 4'd1;
          end
          ST_HOLDOVER: if (good) begin
            state_d   = ST_LOCKED;
            bad_cnt_d = '0;
          end else if (bad_cnt_q + 4'd1 == 4'(UNLOCK_WINDOWS)) begin
            state_d   = ST_UNLOCKED;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + 4'd1;
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end else begin
        cnt_d = cnt_q + WINDOW_LOG2'(1);
        min_d = min_fin;
        max_d = max_fin;
        sum_d = sum_fin;
      end
    end else if (idle_q != 16'(TIMEOUT_CYCLES)) begin
      idle_d = idle_q + 16'd1;
      // Starvation: drop the partial window and lock progress, keep last statistics
      if (idle_q == 16'(TIMEOUT_CYCLES - 1)) begin
        timeout_d  = 1'b1;
        state_d    = ST_UNLOCKED;
        cnt_d      = '0;
        min_d      = '0;
        max_d      = '0;
        sum_d      = '0;
        good_cnt_d = '0;
        bad_cnt_d  = '0;
      end
    end

    locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLDOVER);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_UNLOCKED;
      cnt_q         <= '0;
      min_q         <= '0;
      max_q         <= '0;
      sum_q         <= '0;
      idle_q        <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      err_min_q     <= '0;
      err_max_q     <= '0;
      err_avg_q     <= '0;
      stats_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      min_q         <= min_d;
      max_q         <= max_d;
      sum_q         <= sum_d;
      idle_q        <= idle_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      err_min_q     <= err_min_d;
      err_max_q     <= err_max_d;
      err_avg_q     <= err_avg_d;
      stats_valid_q <= stats_valid_d;
      timeout_q     <= timeout_d;
      locked_q      <= locked_d;
    end
  end

  assign state_o       = state_q;
  assign locked_o      = locked_q;
  assign err_min_o     = err_min_q;
  assign err_max_o     = err_max_q;
  assign err_avg_o     = err_avg_q;
  assign stats_valid_o = stats_valid_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_lock_detector.sv
// Scoreboard bench for lock_detector: expected window statistics are queued by
// the stimulus and popped by a monitor on every stats_valid_o pulse.
module tb_lock_detector;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              sample_valid_i;
  logic signed [7:0] error_i;
  logic              clear_i;
  logic [1:0]        state_o;
  logic              locked_o;
  logic signed [7:0] err_min_o, err_max_o, err_avg_o;
  logic              stats_valid_o;
  logic              timeout_o;

  typedef struct {
    logic signed [7:0] mn;
    logic signed [7:0] mx;
    logic signed [7:0] av;
    logic [1:0]        st;
    logic              lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  lock_detector dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sample_valid_i (sample_valid_i),
    .error_i        (error_i),
    .clear_i        (clear_i),
    .state_o        (state_o),
    .locked_o       (locked_o),
    .err_min_o      (err_min_o),
    .err_max_o      (err_max_o),
    .err_avg_o      (err_avg_o),
    .stats_valid_o  (stats_valid_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the sample was taken
  task automatic send(input logic signed [7:0] v);
    sample_valid_i = 1'b1;
    error_i        = v;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    error_i        = '0;
  endtask

  // Sample 0 = first, odd samples = a, even samples = b
  task automatic window(input logic signed [7:0] first, input logic signed [7:0] a,
                        input logic signed [7:0] b, input exp_t e);
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++)
      send(i == 0 ? first : ((i % 2) == 1 ? a : b));
  endtask

  function automatic exp_t mk(input int mn, input int mx, input int av,
                              input int st, input int lk);
    exp_t e;
    e.mn = 8'(mn);
    e.mx = 8'(mx);
    e.av = 8'(av);
    e.st = 2'(st);
    e.lk = 1'(lk);
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (rst_n_i && stats_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL stats_unexpected actual=1 expected=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("win_min",    int'(err_min_o), int'(e.mn));
        check("win_max",    int'(err_max_o), int'(e.mx));
        check("win_avg",    int'(err_avg_o), int'(e.av));
        check("win_state",  int'(state_o),   int'(e.st));
        check("win_locked", int'(locked_o),  int'(e.lk));
      end
    end
  end

  initial begin
    rst_n_i        = 1'b0;
    sample_valid_i = 1'b0;
    error_i        = '0;
    clear_i        = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_state",   int'(state_o),       0);
    check("rst_locked",  int'(locked_o),      0);
    check("rst_min",     int'(err_min_o),     0);
    check("rst_max",     int'(err_max_o),     0);
    check("rst_avg",     int'(err_avg_o),     0);
    check("rst_stats",   int'(stats_valid_o), 0);
    check("rst_timeout", int'(timeout_o),     0);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // 16 x +3: one good window -> ACQUIRING
    window(3, 3, 3, mk(3, 3, 3, 1, 0));
    check("stats_one_cycle", int'(stats_valid_o), 1);
    @(posedge clk_i);
    #1;
    check("stats_pulse_end", int'(stats_valid_o), 0);

    // Plain clear returns FSM to UNLOCKED
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    check("clear_state", int'(state_o), 0);

    // Four alternating -2/+2 windows -> LOCKED on the fourth
    window(-2, 2, -2, mk(-2, 2, 0, 1, 0));
    window(-2, 2, -2, mk(-2, 2, 0, 1, 0));
    window(-2, 2, -2, mk(-2, 2, 0, 1, 0));
    window(-2, 2, -2, mk(-2, 2, 0, 2, 1));

    // One -5 -> HOLDOVER, good -> LOCKED, two bad -> UNLOCKED
    window(-5, 0, 0, mk(-5, 0, -1, 3, 1));
    window(0, 0, 0,  mk(0, 0, 0, 2, 1));
    window(-5, 0, 0, mk(-5, 0, -1, 3, 1));
    window(-5, 0, 0, mk(-5, 0, -1, 0, 0));

    // Extremes and floor rounding
    window(-128, -128, -128, mk(-128, -128, -128, 0, 0));
    window(-1, 0, -1, mk(-1, 0, -1, 1, 0));

    // Back to LOCKED, then starve with a partial window pending
    window(0, 0, 0, mk(0, 0, 0, 1, 0));
    window(0, 0, 0, mk(0, 0, 0, 1, 0));
    window(0, 0, 0, mk(0, 0, 0, 2, 1));
    for (int i = 0; i < 5; i++) send(1);
    repeat (1023) @(posedge clk_i);
    #1;
    check("timeout_early", int'(timeout_o), 0);
    check("pre_to_state",  int'(state_o),   2);
    @(posedge clk_i);
    #1;
    check("timeout_set",    int'(timeout_o), 1);
    check("timeout_state",  int'(state_o),   0);
    check("timeout_locked", int'(locked_o),  0);
    repeat (20) @(posedge clk_i);
    #1;
    check("timeout_hold", int'(timeout_o), 1);
    exp_q.push_back(mk(0, 7, 0, 0, 0));
    send(7);
    check("timeout_clr", int'(timeout_o), 0);
    for (int i = 0; i < 15; i++) send(0);

    // Reset mid-window
    for (int i = 0; i < 10; i++) send(2);
    rst_n_i = 1'b0;
    #2;
    check("arst_max",    int'(err_max_o), 0);
    check("arst_state",  int'(state_o),   0);
    check("arst_timeout", int'(timeout_o), 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    window(-1, -1, -1, mk(-1, -1, -1, 1, 0));

    // Clear with a coincident sample: the sample is dropped
    sample_valid_i = 1'b1;
    error_i        = 8'sd127;
    clear_i        = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    clear_i        = 1'b0;
    check("clr_smp_state", int'(state_o),   0);
    check("clr_smp_max",   int'(err_max_o), 0);
    window(1, 1, 1, mk(1, 1, 1, 1, 0));

    repeat (4) @(posedge clk_i);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
